// File: rtl/logic_analyzer_capture_fsm.sv
// rtl/logic_analyzer_capture_fsm.sv - capture sequencer for a circular sample buffer with programmable pre-trigger window
module logic_analyzer_capture_fsm #(
    parameter int SAMPLE_DEPTH = 1024,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trig,
    input  logic [15:0]           trigger_loc,
    input  logic                  request_start,
    input  logic                  request_stop,
    output logic [3:0]            state,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    output logic                  bram_we
);

    localparam logic [3:0] IDLE             = 4'd0;
    localparam logic [3:0] MOVE_TO_POSITION = 4'd1;
    localparam logic [3:0] IN_POSITION      = 4'd2;
    localparam logic [3:0] CAPTURING        = 4'd3;
    localparam logic [3:0] CAPTURED         = 4'd4;

    localparam logic [15:0]           DEPTH_M1  = 16'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

    logic                  start_q;
    logic                  stop_q;
    logic                  start_edge;
    logic                  stop_edge;
    logic [15:0]           loc_min;
    logic [ADDR_WIDTH-1:0] loc_clamped;
    logic [ADDR_WIDTH-1:0] pre_len;
    logic [ADDR_WIDTH-1:0] pre_len_next;
    logic [ADDR_WIDTH-1:0] wp_inc;
    logic [ADDR_WIDTH-1:0] rp_inc;
    logic [3:0]            state_next;
    logic [ADDR_WIDTH-1:0] rp_next;
    logic [ADDR_WIDTH-1:0] wp_next;

    assign start_edge = request_start & ~start_q;
    assign stop_edge  = request_stop & ~stop_q;

    // Clamp at full 16-bit width so large trigger_loc values never alias after truncation.
    assign loc_min     = (trigger_loc < DEPTH_M1) ? trigger_loc : DEPTH_M1;
    assign loc_clamped = ADDR_WIDTH'(loc_min);

    // Explicit wrap keeps non-power-of-two depths correct.
    assign wp_inc = (write_pointer == LAST_ADDR) ? '0 : write_pointer + 1'b1;
    assign rp_inc = (read_pointer == LAST_ADDR) ? '0 : read_pointer + 1'b1;

    assign bram_we = (state == MOVE_TO_POSITION) ||
                     (state == IN_POSITION) ||
                     (state == CAPTURING);

    always_comb begin
        state_next   = state;
        rp_next      = read_pointer;
        wp_next      = write_pointer;
        pre_len_next = pre_len;

        if (stop_edge) begin
            state_next = IDLE;
            rp_next    = '0;
            wp_next    = '0;
        end else begin
            case (state)
                IDLE, CAPTURED: begin
                    if (start_edge) begin
                        rp_next      = '0;
                        wp_next      = '0;
                        pre_len_next = loc_clamped;
                        state_next   = (loc_clamped == '0) ? IN_POSITION : MOVE_TO_POSITION;
                    end
                end

                MOVE_TO_POSITION: begin
                    wp_next = wp_inc;
                    if (wp_inc == pre_len) begin
                        state_next = IN_POSITION;
                    end
                end

                // Sliding window: read pointer trails so exactly pre_len samples precede the trigger.
                IN_POSITION: begin
                    wp_next = wp_inc;
                    if (!trig) begin
                        rp_next = rp_inc;
                    end else begin
                        state_next = (wp_inc == read_pointer) ? CAPTURED : CAPTURING;
                    end
                end

                CAPTURING: begin
                    wp_next = wp_inc;
                    if (wp_inc == read_pointer) begin
                        state_next = CAPTURED;
                    end
                end

                default: begin
                    state_next = IDLE;
                    rp_next    = '0;
                    wp_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            read_pointer  <= '0;
            write_pointer <= '0;
            pre_len       <= '0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            state         <= state_next;
            read_pointer  <= rp_next;
            write_pointer <= wp_next;
            pre_len       <= pre_len_next;
            start_q       <= request_start;
            stop_q        <= request_stop;
        end
    end

endmodule

// File: tb/tb_logic_analyzer_capture_fsm.sv
// tb/tb_logic_analyzer_capture_fsm.sv - directed vector bench for logic_analyzer_capture_fsm at depth 8
module tb_logic_analyzer_capture_fsm;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst_n;
    logic          trig;
    logic [15:0]   trigger_loc;
    logic          request_start;
    logic          request_stop;
    logic [3:0]    state;
    logic [AW-1:0] read_pointer;
    logic [AW-1:0] write_pointer;
    logic          bram_we;

    logic_analyzer_capture_fsm #(
        .SAMPLE_DEPTH(DEPTH),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig         (trig),
        .trigger_loc  (trigger_loc),
        .request_start(request_start),
        .request_stop (request_stop),
        .state        (state),
        .read_pointer (read_pointer),
        .write_pointer(write_pointer),
        .bram_we      (bram_we)
    );

    typedef struct {
        logic          start;
        logic          stop;
        logic          trg;
        logic [15:0]   loc;
        logic [3:0]    st;
        logic [AW-1:0] rp;
        logic [AW-1:0] wp;
        logic          we;
    } vec_t;

    vec_t vecs[$];
    int   applied;
    int   miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic s, input logic p, input logic t, input logic [15:0] l,
                                input logic [3:0] st, input logic [AW-1:0] rp,
                                input logic [AW-1:0] wp, input logic we);
        vec_t v;
        v.start = s; v.stop = p; v.trg = t; v.loc = l;
        v.st = st; v.rp = rp; v.wp = wp; v.we = we;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [3:0] st, input logic [AW-1:0] rp,
                         input logic [AW-1:0] wp, input logic we);
        applied++;
        if (state !== st || read_pointer !== rp || write_pointer !== wp || bram_we !== we) begin
            miscompares++;
            $display("FAIL %s: got state=%0d rp=%0d wp=%0d we=%0b, expected state=%0d rp=%0d wp=%0d we=%0b",
                     nm, state, read_pointer, write_pointer, bram_we, st, rp, wp, we);
        end
    endtask

    task automatic step(input string nm, input logic s, input logic p, input logic t,
                        input logic [15:0] l, input logic [3:0] st, input logic [AW-1:0] rp,
                        input logic [AW-1:0] wp, input logic we);
        @(negedge clk);
        request_start = s;
        request_stop  = p;
        trig          = t;
        trigger_loc   = l;
        @(posedge clk);
        #1;
        check(nm, st, rp, wp, we);
    endtask

    initial begin
        applied       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        trig          = 1'b0;
        trigger_loc   = 16'd0;
        request_start = 1'b0;
        request_stop  = 1'b0;

        // Nominal capture, L=3, trigger on third IN_POSITION cycle
        add(0,0,0,3, 0,0,0,0);
        add(1,0,0,3, 1,0,0,1);
        add(1,0,0,3, 1,0,1,1);
        add(1,0,0,3, 1,0,2,1);
        add(1,0,0,3, 2,0,3,1);
        add(1,0,0,3, 2,1,4,1);
        add(1,0,0,3, 2,2,5,1);
        add(1,0,1,3, 3,2,6,1);
        add(1,0,0,3, 3,2,7,1);
        add(1,0,1,3, 3,2,0,1);
        add(1,0,0,3, 3,2,1,1);
        add(1,0,0,3, 4,2,2,0);
        add(1,0,0,3, 4,2,2,0);
        // Zero offset, start edge during CAPTURING ignored
        add(0,0,1,0, 4,2,2,0);
        add(1,0,1,0, 2,0,0,1);
        add(1,0,1,0, 3,0,1,1);
        add(0,0,1,0, 3,0,2,1);
        add(1,0,1,0, 3,0,3,1);
        add(1,0,1,0, 3,0,4,1);
        add(1,0,1,0, 3,0,5,1);
        add(1,0,1,0, 3,0,6,1);
        add(1,0,1,0, 3,0,7,1);
        add(1,0,1,0, 4,0,0,0);
        // Clamped offset: trigger_loc=20 gives L=7
        add(0,0,0,20, 4,0,0,0);
        add(1,0,0,20, 1,0,0,1);
        for (int k = 1; k <= 6; k++) add(1,0,0,20, 1,0,3'(k),1);
        add(1,0,0,20, 2,0,7,1);
        add(1,0,1,20, 4,0,0,0);
        // Stop mid-CAPTURING
        add(0,0,0,3, 4,0,0,0);
        add(1,0,0,3, 1,0,0,1);
        add(1,0,0,3, 1,0,1,1);
        add(1,0,0,3, 1,0,2,1);
        add(1,0,0,3, 2,0,3,1);
        add(1,0,1,3, 3,0,4,1);
        add(1,0,0,3, 3,0,5,1);
        add(1,1,0,3, 0,0,0,0);
        add(1,1,0,3, 0,0,0,0);
        // Reach CAPTURED, then simultaneous start and stop edges
        add(0,0,1,0, 0,0,0,0);
        add(1,0,1,0, 2,0,0,1);
        add(1,0,1,0, 3,0,1,1);
        for (int k = 2; k <= 7; k++) add(1,0,1,0, 3,0,3'(k),1);
        add(1,0,1,0, 4,0,0,0);
        add(0,0,0,0, 4,0,0,0);
        add(1,1,0,0, 0,0,0,0);

        #12;
        check("reset", 4'd0, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].start, vecs[i].stop, vecs[i].trg, vecs[i].loc,
                 vecs[i].st, vecs[i].rp, vecs[i].wp, vecs[i].we);
        end

        // Async reset between edges while IN_POSITION
        step("ar_idle", 0,0,0,2, 4'd0, 3'd0, 3'd0, 1'b0);
        step("ar_start",1,0,0,2, 4'd1, 3'd0, 3'd0, 1'b1);
        step("ar_mv1",  1,0,0,2, 4'd1, 3'd0, 3'd1, 1'b1);
        step("ar_mv2",  1,0,0,2, 4'd2, 3'd0, 3'd2, 1'b1);
        step("ar_inpos",1,0,0,2, 4'd2, 3'd1, 3'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async", 4'd0, 3'd0, 3'd0, 1'b0);
        // request_start held high through release produces an edge on the first clock
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_release_start", 4'd1, 3'd0, 3'd0, 1'b1);
        step("ar_release_wr", 1,0,0,2, 4'd1, 3'd0, 3'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
